count_bit_seq: RTL and testbench

Multi-cycle, dual-requester sequencer for the CLZ/CLO leading-bit count used by the execute stage. It arbitrates round-robin between the two issue pipes and accepts one operand at a time. The operand is scanned one 8-bit slice per cycle, MSB slice first, and the 32-bit count is returned on a valid/ready response port. The block replaces a fully combinational 32-bit leading-count path, taking that path off the execute critical path at the cost of 1–4 scan cycles.

---
 rtl/count_bit_seq.sv | 127 ++++++++++++
 tb/tb_count_bit_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_bit_seq.sv
// Round-robin, two-requester CLZ/CLO sequencer: scans one 8-bit slice per cycle, MSB first.
// Define COUNT_BIT_SEQ_EARLY_EXIT_EN to stop at the first slice that is not all bit_val.
module count_bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_bit_val,
  input  logic [31:0] req0_val,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_bit_val,
  input  logic [31:0] req1_val,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [31:0] operand;
  logic        bit_val;
  logic        id;
  logic        last_grant;
  logic [1:0]  idx;
  logic [5:0]  acc;
`ifndef COUNT_BIT_SEQ_EARLY_EXIT_EN
  logic        stop;
`endif

  logic        accept_ok;
  logic        grant;
  logic        hs;
  logic [7:0]  slice;
  logic [3:0]  c;
  logic        run;

  assign accept_ok = (state == IDLE) && !flush && rst_n;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = accept_ok && req0_valid && !grant;
  assign req1_ready = accept_ok && req1_valid && grant;
  assign hs         = req0_ready || req1_ready;

  assign slice = operand[{idx, 3'b000} +: 8];

  // Run length of bit_val from the slice MSB downward.
  always_comb begin
    c   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (run && (slice[3'(7 - i)] == bit_val)) c = c + 4'd1;
      else                                       run = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      operand    <= '0;
      bit_val    <= 1'b0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      idx        <= '0;
      acc        <= '0;
`ifndef COUNT_BIT_SEQ_EARLY_EXIT_EN
      stop       <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
`ifndef COUNT_BIT_SEQ_EARLY_EXIT_EN
      stop  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            operand    <= grant ? req1_val : req0_val;
            bit_val    <= grant ? req1_bit_val : req0_bit_val;
            id         <= grant;
            last_grant <= grant;
            idx        <= 2'd3;
            acc        <= '0;
`ifndef COUNT_BIT_SEQ_EARLY_EXIT_EN
            stop       <= 1'b0;
`endif
            state      <= SCAN;
          end
        end
        SCAN: begin
`ifdef COUNT_BIT_SEQ_EARLY_EXIT_EN
          acc <= acc + {2'b00, c};
          if (c != 4'd8 || idx == 2'd0) state <= DONE;
          else                          idx   <= idx - 2'd1;
`else
          // Fixed latency: keep walking slices, but freeze acc once a run has ended.
          if (!stop)      acc  <= acc + {2'b00, c};
          if (c != 4'd8)  stop <= 1'b1;
          if (idx == 2'd0) state <= DONE;
          else             idx   <= idx - 2'd1;
`endif
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_id    = id;
  assign resp_count = {26'b0, acc};
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_count_bit_seq.sv
// Scoreboard bench for count_bit_seq: driver pushes expected {id,count,cycle}, monitor pops on response.
module tb_count_bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req0_bit_val = 1'b0;
  logic [31:0] req0_val = '0;
  logic        req1_valid = 1'b0, req1_bit_val = 1'b0;
  logic [31:0] req1_val = '0;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, busy;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_count;

  count_bit_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bit_val(req0_bit_val), .req0_val(req0_val),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bit_val(req1_bit_val), .req1_val(req1_val),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_count(resp_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic id;
    int   count;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   rr_rand = 0;
  logic lg = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lead(input logic b, input logic [31:0] v);
    int n = 0;
    bit run = 1'b1;
    for (int i = 31; i >= 0; i--)
      if (run && v[i] == b) n++;
      else run = 1'b0;
    return n;
  endfunction

  // Cycles from handshake to first resp_valid: slices examined plus one.
  function automatic int lat(input int n);
`ifdef COUNT_BIT_SEQ_EARLY_EXIT_EN
    return ((n >= 32) ? 4 : n / 8 + 1) + 1;
`else
    return 4 + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (q.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        if (!seen) begin
          chk("latency", cyc, q[0].cyc);
          seen = 1'b1;
        end
        chk("resp_id", resp_id, q[0].id);
        chk("resp_count", resp_count, q[0].count);
        if (resp_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic run_op(input logic v0, input logic b0, input logic [31:0] d0,
                        input logic v1, input logic b1, input logic [31:0] d1, input bit keep);
    logic g;
    exp_t e;
    int   tmo = 0;
    req0_valid = v0; req0_bit_val = b0; req0_val = d0;
    req1_valid = v1; req1_bit_val = b1; req1_val = d1;
    forever begin
      @(negedge clk);
      if (req0_ready || req1_ready) break;
      tmo++;
      if (tmo > 300) begin
        chk("hs_timeout", 1, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        return;
      end
    end
    g = (v0 && v1) ? ~lg : v1;
    chk("ready0", req0_ready, !g);
    chk("ready1", req1_ready, g);
    lg = g;
    e.id = g;
    e.count = lead(g ? b1 : b0, g ? d1 : d0);
    e.cyc = cyc + lat(e.count);
    q.push_back(e);
    @(posedge clk); #1;
    if (!keep) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int tmo = 0;
    while (q.size() != 0 && tmo < 300) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic wait_valid();
    int tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!resp_valid && tmo < 50);
    chk("resp_valid_seen", resp_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_count"}, resp_count, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
  endtask

  initial begin
    logic        b0, b1;
    logic [31:0] d0, d1;
    logic [1:0]  sel;

    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    check_reset_outputs("rst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values
    run_op(1, 0, 32'h8000_0000, 0, 0, '0, 0); drain();
    run_op(1, 0, 32'h00F0_0000, 0, 0, '0, 0); drain();
    run_op(0, 0, '0, 1, 1, 32'hFFFF_FFFE, 0); drain();
    run_op(1, 0, 32'h0000_0000, 0, 0, '0, 0); drain();
    run_op(0, 0, '0, 1, 1, 32'hFFFF_FFFF, 0); drain();
    run_op(1, 1, 32'h0FFF_FFFF, 0, 0, '0, 0); drain();

    // Backpressure hold in DONE
    resp_ready = 1'b0;
    run_op(1, 1, 32'hFFFF_FFFE, 0, 0, '0, 0);
    wait_valid();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
      chk("hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    drain();

    // Flush while idle with a request: nothing accepted
    req0_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_idle_ready0", req0_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; req0_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);

    // Flush during SCAN
    run_op(1, 0, 32'h0000_0000, 0, 0, '0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete(); seen = 1'b0;
    chk("flush_scan_busy", busy, 0);
    chk("flush_scan_valid", resp_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    run_op(1, 1, 32'hFFF0_0000, 0, 0, '0, 0); drain();

    // Flush during DONE
    resp_ready = 1'b0;
    run_op(0, 0, '0, 1, 0, 32'h0001_0000, 0);
    wait_valid();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete(); seen = 1'b0;
    chk("flush_done_valid", resp_valid, 0);
    chk("flush_done_busy", busy, 0);
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_op(1, 0, 32'h0000_0100, 0, 0, '0, 0); drain();

    // Async reset mid-SCAN
    run_op(1, 0, 32'h0000_0000, 0, 0, '0, 0);
    #2;
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    q.delete(); seen = 1'b0; lg = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous contention: grants must alternate starting at pipe 0
    for (int i = 0; i < 6; i++) begin
      d0 = $urandom >> $urandom_range(0, 32);
      d1 = $urandom >> $urandom_range(0, 32);
      b0 = 1'($urandom); b1 = 1'($urandom);
      if (b0) d0 = ~d0;
      if (b1) d1 = ~d1;
      run_op(1, b0, d0, 1, b1, d1, (i != 5));
    end
    drain();

    // Randomized traffic with random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom_range(1, 3));
      d0 = $urandom >> $urandom_range(0, 32);
      d1 = $urandom >> $urandom_range(0, 32);
      b0 = 1'($urandom); b1 = 1'($urandom);
      if (b0) d0 = ~d0;
      if (b1) d1 = ~d1;
      run_op(sel[0], b0, d0, sel[1], b1, d1, 0);
    end
    @(posedge clk); #2;
    rr_rand = 1'b0;
    resp_ready = 1'b1;
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
